// File: rtl/multicyc_mem_bridge_pkg.sv
// Shared types and constants for the multicycle CPU memory bridge.
// Build option: MEM_BRIDGE_TIMEOUT_EN enables the bus-wait watchdog.
package MemBridgePkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  // Only naturally aligned word accesses reach the bus.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/multicyc_mem_bridge_if.sv
// Bus-side req/gnt/rvalid port of the memory bridge.
// master = bridge side, slave = memory side.
interface multicyc_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/multicyc_mem_bridge_wdog.sv
// Bus-wait watchdog: counts cycles of an outstanding access.
// Compiled only when MEM_BRIDGE_TIMEOUT_EN is defined.
`ifdef MEM_BRIDGE_TIMEOUT_EN
module mem_bridge_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter, cleared when a new access is launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !expired) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Fires during the LIMIT-th waiting cycle so the bridge leaves on that edge.
  assign expired = (count_r == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/multicyc_mem_bridge.sv
// Turns single-cycle CPU memory accesses into req/gnt/rvalid bus transactions.
// Build option: MEM_BRIDGE_TIMEOUT_EN adds the bus-wait watchdog.
module multicyc_mem_bridge
  import MemBridgePkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_err,
  multicyc_mem_bridge_if.master bus
);

  state_e            state_r;
  state_e            next_state_s;
  logic              accept_s;
  logic              misalign_s;
  logic              capture_s;
  logic              timeout_s;
  logic              expired_s;
  logic              bus_req_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic              cpu_err_r;

  // Next-state selection and decode of the per-cycle datapath events.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    misalign_s   = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          if (word_aligned(cpu_addr[1:0])) begin
            accept_s     = 1'b1;
            next_state_s = REQ;
          end else begin
            misalign_s   = 1'b1;
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          next_state_s = bus_we_r ? DONE : WAIT_R;
        end else if (expired_s) begin
          timeout_s    = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT_R: begin
        if (bus.bus_rvalid) begin
          capture_s    = 1'b1;
          next_state_s = DONE;
        end else if (expired_s) begin
          timeout_s    = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT_R;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic wdog_en_s;

  assign wdog_en_s = (state_r == REQ) || (state_r == WAIT_R);

  mem_bridge_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_s),
    .en      (wdog_en_s),
    .expired (expired_s)
  );
`else
  // No watchdog: a legal TIMEOUT is never negative, so this never expires.
  assign expired_s = (TIMEOUT < 32'sd0);
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bus request/address/data registers and CPU-side result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      cpu_rdata_r <= '0;
      cpu_err_r   <= 1'b0;
    end else begin
      bus_req_r <= (next_state_s == REQ);
      if (accept_s) begin
        bus_we_r    <= cpu_we;
        bus_addr_r  <= cpu_addr;
        bus_wdata_r <= cpu_wdata;
        cpu_err_r   <= 1'b0;
      end else if (misalign_s) begin
        cpu_err_r <= 1'b1;
      end else if (timeout_s) begin
        cpu_err_r   <= 1'b1;
        cpu_rdata_r <= DATA_W'(BUS_ERR_DATA);
      end else if (capture_s) begin
        cpu_rdata_r <= bus.bus_rdata;
      end else begin
        cpu_err_r <= cpu_err_r;
      end
    end
  end

  // DONE is the one cycle the controller may advance past a requested access.
  assign cpu_stall     = cpu_req && (state_r != DONE);
  assign cpu_rdata     = cpu_rdata_r;
  assign cpu_err       = cpu_err_r;
  assign bus.bus_req   = bus_req_r;
  assign bus.bus_we    = bus_we_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_multicyc_mem_bridge.sv
// Directed bench for multicyc_mem_bridge: a transaction-level model derives
// per-cycle expectations; a negedge compare process checks them.
module tb_multicyc_mem_bridge;
  import MemBridgePkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;

  always #5 clk = ~clk;

  multicyc_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  multicyc_mem_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .bus       (bus_if)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          stall_cnt   = 0;
  string       cur         = "init";
  bit          chk_on      = 1'b0;
  bit          e_stall, e_breq, e_chk_bus, e_we, e_chk_res, e_err;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [31:0] m_rdata     = 32'h0;
  bit          m_err       = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", cur, nm, act, exp);
    end
  endtask

  // Per-cycle compare against the expectations posted by the driver.
  always @(negedge clk) begin
    if (chk_on) begin
      if (cpu_stall === 1'b1) stall_cnt++;
      check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      check("bus_req", 32'(bus_if.bus_req), 32'(e_breq));
      if (e_chk_bus) begin
        check("bus_addr", bus_if.bus_addr, e_addr);
        check("bus_wdata", bus_if.bus_wdata, e_wdata);
        check("bus_we", 32'(bus_if.bus_we), 32'(e_we));
      end
      if (e_chk_res) begin
        check("cpu_err", 32'(cpu_err), 32'(e_err));
        check("cpu_rdata", cpu_rdata, e_rdata);
      end
    end
  end

  task automatic drive_bus(input bit gnt, input bit rv, input logic [31:0] rd);
    bus_if.bus_gnt    = gnt;
    bus_if.bus_rvalid = rv;
    bus_if.bus_rdata  = rd;
  endtask

  // One CPU access held until DONE; cycle 0 is the cycle cpu_req rises.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                         input bit no_gnt);
    bit mis;
    int gnt_c, rv_c, done, req_last;
    mis      = (addr[1:0] != 2'b00);
    gnt_c    = 1 + gnt_dly;
    rv_c     = gnt_c + 1 + rv_dly;
    req_last = no_gnt ? TO : gnt_c;
    if (mis)         done = 1;
    else if (no_gnt) done = 1 + TO;
    else if (we)     done = gnt_c + 1;
    else             done = rv_c + 1;
    if (mis) begin
      m_err = 1'b1;
    end else if (no_gnt) begin
      m_err = 1'b1;
      m_rdata = 32'hDEADBEEF;
    end else begin
      m_err = 1'b0;
      if (!we) m_rdata = rdat;
    end
    for (int c = 0; c <= done; c++) begin
      @(posedge clk); #1;
      if (c == 0) stall_cnt = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      if (mis || no_gnt)         drive_bus(1'b0, 1'b0, 32'h0);
      else if (we)               drive_bus(c == gnt_c, c >= 1 && c <= gnt_c, 32'hBAD0BAD0);
      else if (c == rv_c)        drive_bus(1'b0, 1'b1, rdat);
      else                       drive_bus(c == gnt_c, 1'b0, 32'h0BAD0BAD);
      e_stall   = (c < done);
      e_breq    = !mis && c >= 1 && c <= req_last;
      e_chk_bus = e_breq;
      e_addr = addr; e_wdata = wdata; e_we = we;
      e_chk_res = (c == done);
      e_err = m_err; e_rdata = m_rdata;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      drive_bus(1'b0, 1'b0, 32'h0);
      e_stall = 1'b0; e_breq = 1'b0; e_chk_bus = 1'b0;
      e_chk_res = 1'b1; e_err = m_err; e_rdata = m_rdata;
    end
  endtask

  // Hand-computed latency and result for the transaction just finished.
  task automatic pin(input int exp_stalls, input logic [31:0] exp_rd, input bit exp_err);
    @(negedge clk); #1;
    check("stall_cycles", stall_cnt, exp_stalls);
    check("pin_rdata", cpu_rdata, exp_rd);
    check("pin_err", 32'(cpu_err), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    drive_bus(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cur = "reset";
    e_stall = 1'b0; e_breq = 1'b0; e_chk_bus = 1'b1;
    e_addr = 32'h0; e_wdata = 32'h0; e_we = 1'b0;
    e_chk_res = 1'b1; e_err = 1'b0; e_rdata = 32'h0;
    chk_on = 1'b1;
    @(posedge clk); #1;

    cur = "rd_aligned";
    run_txn(1'b0, 32'h100, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);
    pin(3, 32'hCAFEF00D, 1'b0);
    idle(1);

    cur = "wr_gnt_late";
    run_txn(1'b1, 32'h40, 32'h12345678, 3, 0, 32'h0, 1'b0);
    pin(5, 32'hCAFEF00D, 1'b0);

    cur = "b2b_wr";
    run_txn(1'b1, 32'h44, 32'hA5A50F0F, 0, 0, 32'h0, 1'b0);
    pin(2, 32'hCAFEF00D, 1'b0);
    cur = "b2b_rd";
    run_txn(1'b0, 32'h44, 32'h0, 1, 2, 32'h01234567, 1'b0);
    pin(6, 32'h01234567, 1'b0);
    idle(2);

    cur = "misaligned_rd";
    run_txn(1'b0, 32'h102, 32'h0, 0, 0, 32'hFFFFFFFF, 1'b0);
    pin(1, 32'h01234567, 1'b1);
    cur = "misaligned_wr";
    run_txn(1'b1, 32'h41, 32'h9, 0, 0, 32'h0, 1'b0);
    pin(1, 32'h01234567, 1'b1);
    cur = "rd_after_err";
    run_txn(1'b0, 32'h10, 32'h0, 0, 0, 32'h0000BEEF, 1'b0);
    pin(3, 32'h0000BEEF, 1'b0);
    idle(1);

    cur = "rst_in_wait_r";
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_wdata = 32'h0;
    drive_bus(1'b0, 1'b0, 32'h0);
    e_stall = 1'b1; e_breq = 1'b0; e_chk_bus = 1'b0; e_chk_res = 1'b0;
    @(posedge clk); #1;
    drive_bus(1'b1, 1'b0, 32'h0);
    e_breq = 1'b1; e_chk_bus = 1'b1; e_addr = 32'h200; e_wdata = 32'h0; e_we = 1'b0;
    @(posedge clk); #1;
    drive_bus(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    e_breq = 1'b0; e_chk_bus = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0;
    drive_bus(1'b0, 1'b1, 32'hAAAA5555);
    m_rdata = 32'h0; m_err = 1'b0;
    e_stall = 1'b0; e_breq = 1'b0;
    e_chk_bus = 1'b1; e_addr = 32'h0; e_wdata = 32'h0; e_we = 1'b0;
    e_chk_res = 1'b1; e_err = 1'b0; e_rdata = 32'h0;
    @(posedge clk); #1;
    drive_bus(1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    check("rst_rdata", cpu_rdata, 32'h0);
    idle(1);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    cur = "timeout";
    run_txn(1'b0, 32'h80, 32'h0, 0, 0, 32'h0, 1'b1);
    pin(5, 32'hDEADBEEF, 1'b1);
`endif

    idle(2);
    @(negedge clk); #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
